multicore_completion_monitor: RTL and testbench

MULTICORE_COMPLETION_MONITOR -- requirements
Module: multicore_completion_monitor

---
 rtl/multicore_pkg.sv | 23 ++
 rtl/mc_sat_counter.sv | 22 ++
 rtl/multicore_completion_monitor.sv | 131 +++++++++++++
 tb/tb_multicore_completion_monitor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/multicore_pkg.sv
// Shared types, default parameters and width helpers for the multicore completion monitor.
package multicore_pkg;

  localparam int MC_NUM_CORES_DEF = 4;
  localparam int MC_CNT_W_DEF     = 24;
  localparam int MC_TIMEOUT_DEF   = 100000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    TOUT
  } mc_state_t;

  function automatic int sel_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mc_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module mc_sat_counter #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multicore_completion_monitor.sv
// Tracks per-core completion of a run and records the cycle each core finished.
// Optional watchdog is compiled in with macro MCMON_TIMEOUT_EN.
module multicore_completion_monitor
  import multicore_pkg::*;
#(
  parameter int NUM_CORES      = MC_NUM_CORES_DEF,
  parameter int CNT_W          = MC_CNT_W_DEF,
  parameter int TIMEOUT_CYCLES = MC_TIMEOUT_DEF,
  localparam int SEL_W         = sel_w(NUM_CORES),
  localparam int IDX_W         = idx_w(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SEL_W-1:0]     core_sel,
  input  logic [NUM_CORES-1:0] end_op,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [CNT_W-1:0]     rd_cycles,
  output logic [NUM_CORES-1:0] active_mask,
  output logic [NUM_CORES-1:0] done_mask,
  output logic                 busy,
  output logic                 all_done,
  output logic                 timeout
);

  mc_state_t            state;
  mc_state_t            next_state;
  logic [CNT_W-1:0]     cnt;
  logic                 start_acc;
  logic [SEL_W-1:0]     sel_n;
  logic [NUM_CORES-1:0] new_mask;
  logic [NUM_CORES-1:0] new_done;
  logic                 complete;
  logic                 wd_hit;
  logic [CNT_W-1:0]     cap [NUM_CORES];

  assign start_acc = start && (state != RUN);
  assign new_done  = end_op & active_mask & ~done_mask;
  assign complete  = (state == RUN) && (((done_mask | new_done) & active_mask) == active_mask);

`ifdef MCMON_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  assign wd_hit = (state == RUN) && (cnt == TO_LAST);
`else
  assign wd_hit = 1'b0;
`endif

  // core_sel of 0 still enables one core; oversize requests clamp to NUM_CORES
  always_comb begin
    sel_n = core_sel;
    if (core_sel == '0) begin
      sel_n = SEL_W'(1);
    end else if (core_sel > SEL_W'(NUM_CORES)) begin
      sel_n = SEL_W'(NUM_CORES);
    end
    new_mask = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      new_mask[i] = (i < int'(sel_n));
    end
  end

  mc_sat_counter #(.CNT_W(CNT_W)) u_run_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start_acc),
    .enable (state == RUN),
    .count  (cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, TOUT: if (start) next_state = RUN;
      RUN: begin
        if (complete) begin
          next_state = DONE;
        end else if (wd_hit) begin
          next_state = TOUT;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
`ifdef MCMON_TIMEOUT_EN
    timeout = (state == TOUT);
`else
    timeout = 1'b0;
`endif
  end

  // all_done marks only the first DONE cycle, so it is registered off the completing RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_mask <= '0;
      done_mask   <= '0;
      all_done    <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) cap[i] <= '0;
    end else begin
      all_done <= complete;
      if (start_acc) begin
        active_mask <= new_mask;
        done_mask   <= '0;
        for (int i = 0; i < NUM_CORES; i++) cap[i] <= '0;
      end else if (state == RUN) begin
        done_mask <= done_mask | new_done;
        for (int i = 0; i < NUM_CORES; i++) begin
          if (new_done[i]) cap[i] <= cnt;
        end
      end
    end
  end

  always_comb begin
    rd_cycles = '0;
    if ({1'b0, rd_idx} < (IDX_W + 1)'(NUM_CORES)) begin
      rd_cycles = cap[rd_idx];
    end
  end

endmodule

// File: tb/tb_multicore_completion_monitor.sv
// Randomized bench for multicore_completion_monitor against a per-run completion model.
// Define MCMON_TIMEOUT_EN on both RTL and bench to exercise the watchdog with TIMEOUT_CYCLES=50.
module tb_multicore_completion_monitor;

  localparam int NC    = 4;
  localparam int CW    = 24;
  localparam int TO    = 50;
  localparam int SW    = 3;
  localparam int IW    = 2;
  localparam int NEVER = 1 << 20;
`ifdef MCMON_TIMEOUT_EN
  localparam int TO_LAST = TO - 1;
`else
  localparam int TO_LAST = 1 << 30;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [SW-1:0] core_sel;
  logic [NC-1:0] end_op;
  logic [IW-1:0] rd_idx;
  logic [CW-1:0] rd_cycles;
  logic [NC-1:0] active_mask;
  logic [NC-1:0] done_mask;
  logic          busy;
  logic          all_done;
  logic          timeout;

  int total = 0;
  int bad   = 0;

  multicore_completion_monitor #(
    .NUM_CORES      (NC),
    .CNT_W          (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .core_sel    (core_sel),
    .end_op      (end_op),
    .rd_idx      (rd_idx),
    .rd_cycles   (rd_cycles),
    .active_mask (active_mask),
    .done_mask   (done_mask),
    .busy        (busy),
    .all_done    (all_done),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " all_done"}, 32'(all_done), 32'd0);
    checkOutput({tag, " timeout"}, 32'(timeout), 32'd0);
    checkOutput({tag, " active_mask"}, 32'(active_mask), 32'd0);
    checkOutput({tag, " done_mask"}, 32'(done_mask), 32'd0);
    for (int i = 0; i < NC; i++) begin
      rd_idx = IW'(i);
      #1;
      checkOutput({tag, " rd_cycles"}, 32'(rd_cycles), 32'd0);
    end
  endtask

  // One run: rise[i] is the RUN cycle where active core i first raises end_op
  task automatic applyStimulus(input int sel, input int rise [NC], input bit noise, input bit poke);
    int nact;
    int cmax;
    int stop;
    logic [NC-1:0] act;
    logic [NC-1:0] exp_done;
    logic [NC-1:0] eo;
    nact = (sel == 0) ? 1 : ((sel > NC) ? NC : sel);
    act  = '0;
    cmax = 0;
    for (int i = 0; i < nact; i++) begin
      act[i] = 1'b1;
      if (rise[i] > cmax) cmax = rise[i];
    end
    stop = (cmax <= TO_LAST) ? cmax : TO_LAST;

    @(negedge clk);
    start    = 1'b1;
    core_sel = SW'(sel);
    end_op   = '0;
    for (int k = 0; k <= stop + 2; k++) begin
      @(negedge clk);
      start = 1'b0;
      exp_done = '0;
      for (int i = 0; i < nact; i++) begin
        if (rise[i] < k && rise[i] <= stop) exp_done[i] = 1'b1;
      end
      checkOutput("busy", 32'(busy), 32'(k <= stop));
      checkOutput("all_done", 32'(all_done), 32'((cmax <= TO_LAST) && (k == stop + 1)));
      checkOutput("timeout", 32'(timeout), 32'((cmax > TO_LAST) && (k > stop)));
      checkOutput("active_mask", 32'(active_mask), 32'(act));
      checkOutput("done_mask", 32'(done_mask), 32'(exp_done));
      for (int i = 0; i < NC; i++) begin
        if (i < nact) begin
          eo[i] = (k == rise[i]) || ((k > rise[i]) && ($urandom_range(0, 1) == 1));
        end else begin
          eo[i] = noise ? ($urandom_range(0, 1) == 1) : (k >= rise[i]);
        end
      end
      end_op = eo;
      if (poke && k >= 1 && k <= stop && $urandom_range(0, 3) == 0) begin
        start    = 1'b1;
        core_sel = SW'($urandom_range(0, 7));
      end
    end
    start  = 1'b0;
    end_op = '0;
    for (int i = 0; i < NC; i++) begin
      rd_idx = IW'(i);
      #1;
      checkOutput("rd_cycles", 32'(rd_cycles),
                  (act[i] && rise[i] <= stop) ? 32'(rise[i]) : 32'd0);
    end
  endtask

  initial begin
    int r [NC];
    rst_n    = 1'b0;
    start    = 1'b0;
    core_sel = '0;
    end_op   = '0;
    rd_idx   = '0;
    @(negedge clk);
    @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    $display("[TB] staggered completion, four cores");
    r = '{5, 9, 12, 20};
    applyStimulus(4, r, 1'b0, 1'b0);

    $display("[TB] two active cores, inactive cores high from cycle 0");
    r = '{7, 7, 0, 0};
    applyStimulus(2, r, 1'b0, 1'b0);

    $display("[TB] core_sel clamping");
    r = '{3, 8, 8, 8};
    applyStimulus(0, r, 1'b1, 1'b0);
    r = '{4, 4, 11, 2};
    applyStimulus(7, r, 1'b1, 1'b0);

    $display("[TB] start pulses during RUN");
    r = '{6, 0, 15, 9};
    applyStimulus(4, r, 1'b1, 1'b1);

    $display("[TB] randomized runs");
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < NC; i++) r[i] = $urandom_range(0, 30);
      applyStimulus($urandom_range(0, 7), r, 1'b1, 1'b1);
    end

    $display("[TB] reset mid-run");
    @(negedge clk);
    start    = 1'b1;
    core_sel = SW'(4);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      end_op = (k >= 2) ? 4'b0100 : 4'b0000;
      @(negedge clk);
    end
    checkOutput("pre-reset done_mask", 32'(done_mask), 32'h4);
    #1 rst_n = 1'b0;
    #1;
    checkAllZero("async reset");
    end_op = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    r = '{1, 4, 2, 3};
    applyStimulus(3, r, 1'b1, 1'b0);

`ifdef MCMON_TIMEOUT_EN
    $display("[TB] watchdog, core 3 never ends");
    r = '{3, 6, 10, NEVER};
    applyStimulus(4, r, 1'b0, 1'b0);
    r = '{2, 5, 1, 7};
    applyStimulus(4, r, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
